// File: rtl/data_write_buffer_if.sv
// Core/dataram bundle for the posted-store write buffer.
// slave: buffer side; master: core plus dataram side.
interface data_write_buffer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int BUS_WIDTH  = 17
);
   logic                  cpu_read;
   logic                  cpu_write;
   logic [BUS_WIDTH-1:0]  cpu_adr;
   logic [DATA_WIDTH-1:0] cpu_wd;
   logic [DATA_WIDTH-1:0] cpu_rd;
   logic                  cpu_stall;
   logic                  mem_write;
   logic [BUS_WIDTH-1:0]  mem_adr;
   logic [DATA_WIDTH-1:0] mem_wd;
   logic [DATA_WIDTH-1:0] mem_rd;
   logic                  buf_empty;

   modport slave (
      input  cpu_read, cpu_write, cpu_adr, cpu_wd, mem_rd,
      output cpu_rd, cpu_stall, mem_write, mem_adr, mem_wd,
      output buf_empty
   );

   modport master (
      output cpu_read, cpu_write, cpu_adr, cpu_wd, mem_rd,
      input  cpu_rd, cpu_stall, mem_write, mem_adr, mem_wd,
      input  buf_empty
   );
endinterface

// File: rtl/data_write_buffer.sv
// Posted-store FIFO between core data port and single-port dataram.
// Ports: clk, reset (async, active-low), bus (slave modport).
module data_write_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int BUS_WIDTH  = 17,
   parameter int DEPTH      = 4
) (
   input  logic               clk,
   input  logic               reset,
   data_write_buffer_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [BUS_WIDTH-1:0]  r_adr [DEPTH];
   logic [DATA_WIDTH-1:0] r_dat [DEPTH];
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [CW-1:0]         r_count;

   logic                  w_rd;
   logic                  w_wr;
   logic                  w_idle;
   logic                  w_full;
   logic                  w_nempty;
   logic                  w_hit;
   logic                  w_drain;
   logic                  w_enq;
   logic [DATA_WIDTH-1:0] w_fwd;

   // read+write together is treated as a write
   assign w_wr     = bus.cpu_write;
   assign w_rd     = bus.cpu_read & ~bus.cpu_write;
   assign w_idle   = ~bus.cpu_read & ~bus.cpu_write;
   assign w_full   = (r_count == CW'(DEPTH));
   assign w_nempty = (r_count != '0);

   // scan oldest to youngest so the youngest match wins
   always_comb begin
      logic [PW-1:0] v_idx;
      w_hit = 1'b0;
      w_fwd = '0;
      v_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         v_idx = r_head + PW'(i);
         if ((CW'(i) < r_count) &&
             (r_adr[v_idx][BUS_WIDTH-1:2] ==
              bus.cpu_adr[BUS_WIDTH-1:2])) begin
            w_hit = 1'b1;
            w_fwd = r_dat[v_idx];
         end
      end
   end

   assign w_drain = w_nempty &
                    (w_idle | (w_rd & w_hit) | (w_wr & w_full));
   assign w_enq   = w_wr & ~w_full;

   assign bus.mem_write = w_drain;
   assign bus.mem_adr   = w_drain ? r_adr[r_head] : bus.cpu_adr;
   assign bus.mem_wd    = r_dat[r_head];
   assign bus.cpu_stall = w_wr & w_full;
   assign bus.buf_empty = ~w_nempty;
   // a miss is coherent in RAM: no pending store covers that word
   assign bus.cpu_rd    = ~w_rd ? '0 :
                          w_hit ? w_fwd : bus.mem_rd;

   // drain and enqueue are exclusive: full writes stall instead
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_adr[i] <= '0;
            r_dat[i] <= '0;
         end
      end else if (w_drain) begin
         r_head  <= r_head + PW'(1);
         r_count <= r_count - CW'(1);
      end else if (w_enq) begin
         r_adr[r_tail] <= bus.cpu_adr;
         r_dat[r_tail] <= bus.cpu_wd;
         r_tail        <= r_tail + PW'(1);
         r_count       <= r_count + CW'(1);
      end
   end
endmodule
